// File: rtl/lowspeed_pkg.sv
// Shared definitions for the low-speed status blocks: blink FSM encoding,
// default timing constants and a width helper.
package lowspeed_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PULSE_ON  = 2'd1,
        ST_PULSE_OFF = 2'd2,
        ST_GAP       = 2'd3
    } blink_state_t;

    localparam int DEFAULT_NUM_LEDS    = 4;
    localparam int DEFAULT_ERROR_WIDTH = 8;
    localparam int DEFAULT_TICK_CYCLES = 1200000;
    localparam int DEFAULT_ON_TICKS    = 2;
    localparam int DEFAULT_OFF_TICKS   = 3;
    localparam int DEFAULT_GAP_TICKS   = 10;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int width;
        width = 0;
        for (int w = 0; w < 31; w++) begin
            if ((32'd1 << w) < $unsigned(value)) begin
                width = w + 1;
            end
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running prescaler producing a one-cycle tick every TICK_CYCLES clocks;
// hold_i parks the count at zero so the next period starts with a full phase.
module tick_divider
    import lowspeed_pkg::*;
#(
    parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic hold_i,
    output logic tick_o
);

    localparam int                CNT_W    = clog2_min1(TICK_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == CNT_LAST);
    assign tick_o    = w_at_last & ~hold_i;

    // Prescaler count: cleared while held, wraps after the last cycle of a tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (hold_i) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_at_last) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_error_blinker.sv
// LED driver: passes user LED values through until an error latches, then
// blinks LED 0 with a pulse count naming the lowest-numbered sticky error.
module led_error_blinker
    import lowspeed_pkg::*;
#(
    parameter int NUM_LEDS    = DEFAULT_NUM_LEDS,
    parameter int ERROR_WIDTH = DEFAULT_ERROR_WIDTH,
    parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES,
    parameter int ON_TICKS    = DEFAULT_ON_TICKS,
    parameter int OFF_TICKS   = DEFAULT_OFF_TICKS,
    parameter int GAP_TICKS   = DEFAULT_GAP_TICKS
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [ERROR_WIDTH-1:0] error_i,
    input  logic                   clear_i,
    input  logic [NUM_LEDS-1:0]    led_value_i,
    output logic [NUM_LEDS-1:0]    led_pin_o,
    output logic [ERROR_WIDTH-1:0] error_sticky_o,
    output logic                   error_active_o
);

    localparam int CODE_W   = clog2_min1(ERROR_WIDTH + 1);
    localparam int MAX_OF2  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TICK_MAX = (MAX_OF2 > GAP_TICKS) ? MAX_OF2 : GAP_TICKS;
    localparam int TCNT_W   = clog2_min1(TICK_MAX);

    localparam logic [TCNT_W-1:0] ON_LAST  = TCNT_W'(ON_TICKS - 1);
    localparam logic [TCNT_W-1:0] OFF_LAST = TCNT_W'(OFF_TICKS - 1);
    localparam logic [TCNT_W-1:0] GAP_LAST = TCNT_W'(GAP_TICKS - 1);

    blink_state_t            r_state;
    blink_state_t            w_state_nxt;
    logic [ERROR_WIDTH-1:0]  r_sticky;
    logic                    r_active;
    logic [CODE_W-1:0]       r_code;
    logic [CODE_W-1:0]       w_code_nxt;
    logic [TCNT_W-1:0]       r_tick_cnt;
    logic [TCNT_W-1:0]       w_tick_cnt_nxt;
    logic [CODE_W-1:0]       r_pulse_cnt;
    logic [CODE_W-1:0]       w_pulse_cnt_nxt;
    logic [CODE_W-1:0]       w_pulse_inc;
    logic [CODE_W-1:0]       w_lowest;
    logic [NUM_LEDS-1:0]     r_led;
    logic                    w_any_sticky;
    logic                    w_hold;
    logic                    w_tick;

    // Lowest set bit wins: iterate from the top so lower indices overwrite.
    function automatic logic [CODE_W-1:0] lowest_code(input logic [ERROR_WIDTH-1:0] bits);
        logic [CODE_W-1:0] code;
        code = {CODE_W{1'b0}};
        for (int i = ERROR_WIDTH - 1; i >= 0; i--) begin
            if (bits[i]) begin
                code = CODE_W'(i + 1);
            end
        end
        return code;
    endfunction

    assign w_any_sticky = |r_sticky;
    assign w_hold       = (r_state == ST_IDLE);
    assign w_pulse_inc  = r_pulse_cnt + CODE_W'(1);
    assign w_lowest     = lowest_code(r_sticky);

    tick_divider #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_divider (
        .clock   (clock),
        .reset_n (reset_n),
        .hold_i  (w_hold),
        .tick_o  (w_tick)
    );

    // Sticky error capture; a new error in the clearing cycle survives the clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sticky <= {ERROR_WIDTH{1'b0}};
            r_active <= 1'b0;
        end else begin
            r_sticky <= (clear_i ? {ERROR_WIDTH{1'b0}} : r_sticky) | error_i;
            r_active <= w_any_sticky;
        end
    end

    // Blink sequencer next-state; an empty sticky register aborts from any state.
    always_comb begin
        w_state_nxt     = r_state;
        w_code_nxt      = r_code;
        w_tick_cnt_nxt  = r_tick_cnt;
        w_pulse_cnt_nxt = r_pulse_cnt;
        if (!w_any_sticky) begin
            w_state_nxt     = ST_IDLE;
            w_tick_cnt_nxt  = {TCNT_W{1'b0}};
            w_pulse_cnt_nxt = {CODE_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt     = ST_PULSE_ON;
                    w_code_nxt      = w_lowest;
                    w_tick_cnt_nxt  = {TCNT_W{1'b0}};
                    w_pulse_cnt_nxt = {CODE_W{1'b0}};
                end
                ST_PULSE_ON: begin
                    if (w_tick && (r_tick_cnt == ON_LAST)) begin
                        w_tick_cnt_nxt  = {TCNT_W{1'b0}};
                        w_pulse_cnt_nxt = w_pulse_inc;
                        if (w_pulse_inc == r_code) begin
                            w_state_nxt = ST_GAP;
                        end else begin
                            w_state_nxt = ST_PULSE_OFF;
                        end
                    end else if (w_tick) begin
                        w_tick_cnt_nxt = r_tick_cnt + TCNT_W'(1);
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt;
                    end
                end
                ST_PULSE_OFF: begin
                    if (w_tick && (r_tick_cnt == OFF_LAST)) begin
                        w_tick_cnt_nxt = {TCNT_W{1'b0}};
                        w_state_nxt    = ST_PULSE_ON;
                    end else if (w_tick) begin
                        w_tick_cnt_nxt = r_tick_cnt + TCNT_W'(1);
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt;
                    end
                end
                ST_GAP: begin
                    if (w_tick && (r_tick_cnt == GAP_LAST)) begin
                        w_state_nxt     = ST_PULSE_ON;
                        w_code_nxt      = w_lowest;
                        w_tick_cnt_nxt  = {TCNT_W{1'b0}};
                        w_pulse_cnt_nxt = {CODE_W{1'b0}};
                    end else if (w_tick) begin
                        w_tick_cnt_nxt = r_tick_cnt + TCNT_W'(1);
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt;
                    end
                end
                default: begin
                    w_state_nxt     = ST_IDLE;
                    w_tick_cnt_nxt  = {TCNT_W{1'b0}};
                    w_pulse_cnt_nxt = {CODE_W{1'b0}};
                end
            endcase
        end
    end

    // Sequencer state and counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_code      <= {CODE_W{1'b0}};
            r_tick_cnt  <= {TCNT_W{1'b0}};
            r_pulse_cnt <= {CODE_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_code      <= w_code_nxt;
            r_tick_cnt  <= w_tick_cnt_nxt;
            r_pulse_cnt <= w_pulse_cnt_nxt;
        end
    end

    // Pin register: user values when idle, otherwise upper LEDs flag error mode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_led <= {NUM_LEDS{1'b0}};
        end else if (r_state == ST_IDLE) begin
            r_led <= led_value_i;
        end else begin
            r_led <= {{(NUM_LEDS-1){1'b1}}, (r_state == ST_PULSE_ON)};
        end
    end

    assign led_pin_o      = r_led;
    assign error_sticky_o = r_sticky;
    assign error_active_o = r_active;

endmodule

// File: tb/tb_led_error_blinker.sv
// Directed bench for led_error_blinker with a short tick period so whole
// blink codes fit in a few hundred cycles.
module tb_led_error_blinker;

    localparam int TICK    = 4;
    localparam int ON_CYC  = 2 * TICK;
    localparam int OFF_CYC = 3 * TICK;
    localparam int GAP_CYC = 10 * TICK;

    logic       clock;
    logic       reset_n;
    logic [7:0] error_i;
    logic       clear_i;
    logic [3:0] led_value_i;
    logic [3:0] led_pin_o;
    logic [7:0] error_sticky_o;
    logic       error_active_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] err;
        logic       clr;
        logic [3:0] led;
        logic [7:0] exp_sticky;
        logic       exp_active;
        logic [3:0] exp_pins;
    } vec_t;

    vec_t vecs [14];

    led_error_blinker #(
        .NUM_LEDS    (4),
        .ERROR_WIDTH (8),
        .TICK_CYCLES (TICK),
        .ON_TICKS    (2),
        .OFF_TICKS   (3),
        .GAP_TICKS   (10)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .error_i        (error_i),
        .clear_i        (clear_i),
        .led_value_i    (led_value_i),
        .led_pin_o      (led_pin_o),
        .error_sticky_o (error_sticky_o),
        .error_active_o (error_active_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected LED 0 level t cycles after the first lit cycle of a code.
    function automatic logic exp_pin0(input int t, input int code);
        int period;
        int pos;
        period = code * ON_CYC + (code - 1) * OFF_CYC + GAP_CYC;
        pos    = t % period;
        return ((pos / (ON_CYC + OFF_CYC)) < code) && ((pos % (ON_CYC + OFF_CYC)) < ON_CYC);
    endfunction

    // Starts from IDLE with empty sticky register; ends at posedge+1.
    task automatic run_code(input logic [7:0] err, input int code, input int ncycles, input string tag);
        logic [3:0] led_now;
        led_now = led_value_i;
        error_i = err;
        @(posedge clock); #1;
        error_i = 8'h00;
        check($sformatf("%s sticky", tag), error_sticky_o, err);
        @(posedge clock); #1;
        check($sformatf("%s latency pins", tag), led_pin_o, led_now);
        check($sformatf("%s active", tag), error_active_o, 1'b1);
        for (int t = 0; t < ncycles; t++) begin
            @(posedge clock); #1;
            check($sformatf("%s pin0 t=%0d", tag, t), led_pin_o[0], exp_pin0(t, code));
            check($sformatf("%s mode t=%0d", tag, t), led_pin_o[3:1], 3'b111);
        end
    endtask

    task automatic go_idle(input string tag);
        clear_i = 1'b1;
        @(posedge clock); #1;
        clear_i = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
        end
        check($sformatf("%s idle pins", tag), led_pin_o, led_value_i);
    endtask

    initial begin
        reset_n     = 1'b0;
        error_i     = 8'h00;
        clear_i     = 1'b0;
        led_value_i = 4'b1010;

        vecs[0]  = '{8'h00, 1'b0, 4'b1010, 8'h00, 1'b0, 4'b1010};
        vecs[1]  = '{8'h00, 1'b0, 4'b0101, 8'h00, 1'b0, 4'b0101};
        vecs[2]  = '{8'h04, 1'b0, 4'b0101, 8'h04, 1'b0, 4'b0101};
        vecs[3]  = '{8'h00, 1'b0, 4'b0011, 8'h04, 1'b1, 4'b0011};
        vecs[4]  = '{8'h00, 1'b0, 4'b0011, 8'h04, 1'b1, 4'b1111};
        vecs[5]  = '{8'h00, 1'b0, 4'b0011, 8'h04, 1'b1, 4'b1111};
        vecs[6]  = '{8'h00, 1'b1, 4'b0011, 8'h00, 1'b1, 4'b1111};
        vecs[7]  = '{8'h00, 1'b0, 4'b0110, 8'h00, 1'b0, 4'b1111};
        vecs[8]  = '{8'h00, 1'b0, 4'b0110, 8'h00, 1'b0, 4'b0110};
        vecs[9]  = '{8'h01, 1'b1, 4'b0110, 8'h01, 1'b0, 4'b0110};
        vecs[10] = '{8'h80, 1'b0, 4'b0110, 8'h81, 1'b1, 4'b0110};
        vecs[11] = '{8'h00, 1'b1, 4'b0110, 8'h00, 1'b1, 4'b1111};
        vecs[12] = '{8'h00, 1'b0, 4'b1001, 8'h00, 1'b0, 4'b1111};
        vecs[13] = '{8'h00, 1'b0, 4'b1001, 8'h00, 1'b0, 4'b1001};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset pins", led_pin_o, 4'b0000);
        check("reset sticky", error_sticky_o, 8'h00);
        check("reset active", error_active_o, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        // Single-cycle vector table
        for (int i = 0; i < 14; i++) begin
            error_i     = vecs[i].err;
            clear_i     = vecs[i].clr;
            led_value_i = vecs[i].led;
            @(posedge clock); #1;
            error_i = 8'h00;
            clear_i = 1'b0;
            check($sformatf("vec%0d sticky", i), error_sticky_o, vecs[i].exp_sticky);
            check($sformatf("vec%0d active", i), error_active_o, vecs[i].exp_active);
            check($sformatf("vec%0d pins", i), led_pin_o, vecs[i].exp_pins);
        end

        // Code 3 over two full periods
        led_value_i = 4'b0110;
        run_code(8'h04, 3, 2 * 88 + 4, "code3");
        go_idle("after code3");

        // Code 2 from two simultaneous errors
        run_code(8'h22, 2, 68 + 10, "code2");
        go_idle("after code2");

        // Clear and set in the same cycle keep the sequence alive
        run_code(8'h10, 5, 10, "code5");
        clear_i = 1'b1;
        error_i = 8'h01;
        @(posedge clock); #1;
        clear_i = 1'b0;
        error_i = 8'h00;
        check("clr+set sticky", error_sticky_o, 8'h01);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            check($sformatf("clr+set mode k=%0d", k), led_pin_o[3:1], 3'b111);
            check($sformatf("clr+set active k=%0d", k), error_active_o, 1'b1);
        end
        go_idle("after clr+set");

        // Clear mid second pulse, then a fresh restart
        led_value_i = 4'b0101;
        run_code(8'h04, 3, 23, "abort");
        check("abort in pulse2", led_pin_o[0], 1'b1);
        clear_i = 1'b1;
        @(posedge clock); #1;
        clear_i = 1'b0;
        check("abort sticky", error_sticky_o, 8'h00);
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("abort pins", led_pin_o, 4'b0101);
        repeat (10) @(posedge clock);
        #1;
        run_code(8'h04, 3, 30, "restart");
        go_idle("after restart");

        // Asynchronous reset in the gap
        run_code(8'h04, 3, 60, "gap");
        #3;
        reset_n = 1'b0;
        #1;
        check("async pins", led_pin_o, 4'b0000);
        check("async sticky", error_sticky_o, 8'h00);
        check("async active", error_active_o, 1'b0);
        led_value_i = 4'b1100;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("post reset pins", led_pin_o, 4'b1100);
        check("post reset active", error_active_o, 1'b0);
        check("post reset sticky", error_sticky_o, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
